// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the 16-point FFT twiddle stage.
//   - DW_DEF / TW_DEF : default data and twiddle widths
//   - Q_SHIFT / Q_ROUND : Q1.14 renormalisation shift and round-half-up constant
//   - TW_RE / TW_IM : twiddle ROM indexed by exponent e = k*n (0..9)
//   - cplx_t : complex value at the default width
package fft_pkg;

    localparam int unsigned DW_DEF  = 16;
    localparam int unsigned TW_DEF  = 16;
    localparam int          Q_SHIFT = 14;
    localparam int          Q_ROUND = 8192;
    localparam int unsigned NUM_EXP = 10;

    // W16^e = cos(2*pi*e/16) - j*sin(2*pi*e/16) in Q1.14; e = 5, 7, 8 never occur.
    localparam logic signed [TW_DEF-1:0] TW_RE [NUM_EXP] = '{
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270, 16'sd0,
        16'sd0,     -16'sd11585,  16'sd0,      16'sd0,   -16'sd15137
    };
    localparam logic signed [TW_DEF-1:0] TW_IM [NUM_EXP] = '{
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137, -16'sd16384,
        16'sd0,     -16'sd11585,  16'sd0,      16'sd0,      16'sd6270
    };

    typedef struct packed {
        logic signed [TW_DEF-1:0] re;
        logic signed [TW_DEF-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_cmult.sv
// fft_cmult: 2-stage complex multiply (a + jb) * (wr + jwi), round, reduce to DW bits.
//   Stage 1 registers the four partial products, stage 2 the rounded sums.
//   Config macro FFT_TW_SAT_EN: defined -> saturate to DW bits, undefined -> wrap.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_sof     sample valid / start of frame
//   in_r, in_i           sample real / imaginary (DW, signed)
//   tw_r, tw_i           twiddle real / imaginary (TW, Q1.14)
//   out_valid, out_sof   inputs delayed by 2 cycles
//   out_r, out_i         product (DW, signed); held while out_valid = 0
module fft_cmult
    import fft_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    input  logic [TW-1:0] tw_r,
    input  logic [TW-1:0] tw_i,
    output logic          out_valid,
    output logic          out_sof,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i
);

    localparam int unsigned PW = DW + TW;
    localparam int unsigned SW = PW + 1;

    logic signed [PW-1:0] ar_q, ar_d, bi_q, bi_d, ai_q, ai_d, br_q, br_d;
    logic                 v1_q, v1_d, s1_q, s1_d;
    logic signed [SW-1:0] sum_r, sum_i, rnd_r, rnd_i;
    logic        [DW-1:0] res_r, res_i;
    logic        [DW-1:0] r2_q, r2_d, i2_q, i2_d;
    logic                 v2_q, v2_d, s2_q, s2_d;

    // Stage 1: products only load on a valid sample so gaps leave them untouched.
    always_comb begin
        ar_d = ar_q;
        bi_d = bi_q;
        ai_d = ai_q;
        br_d = br_q;
        v1_d = in_valid;
        s1_d = in_valid & in_sof;
        if (in_valid) begin
            ar_d = PW'($signed(in_r)) * PW'($signed(tw_r));
            bi_d = PW'($signed(in_i)) * PW'($signed(tw_i));
            ai_d = PW'($signed(in_r)) * PW'($signed(tw_i));
            br_d = PW'($signed(in_i)) * PW'($signed(tw_r));
        end
    end

    always_comb begin
        sum_r = SW'(ar_q) - SW'(bi_q);
        sum_i = SW'(ai_q) + SW'(br_q);
        rnd_r = (sum_r + SW'(Q_ROUND)) >>> Q_SHIFT;
        rnd_i = (sum_i + SW'(Q_ROUND)) >>> Q_SHIFT;
    end

`ifdef FFT_TW_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res_r = rnd_r[DW-1:0];
        res_i = rnd_i[DW-1:0];
        if (rnd_r > SAT_MAX) res_r = SAT_MAX[DW-1:0];
        else if (rnd_r < SAT_MIN) res_r = SAT_MIN[DW-1:0];
        if (rnd_i > SAT_MAX) res_i = SAT_MAX[DW-1:0];
        else if (rnd_i < SAT_MIN) res_i = SAT_MIN[DW-1:0];
    end
`else
    // Two's-complement wrap, same overflow behaviour as the upstream butterfly.
    logic unused_hi;

    always_comb begin
        res_r = rnd_r[DW-1:0];
        res_i = rnd_i[DW-1:0];
    end
    assign unused_hi = ^{rnd_r[SW-1:DW], rnd_i[SW-1:DW]};
`endif

    // Stage 2: result registers hold their value across gaps.
    always_comb begin
        r2_d = r2_q;
        i2_d = i2_q;
        v2_d = v1_q;
        s2_d = s1_q;
        if (v1_q) begin
            r2_d = res_r;
            i2_d = res_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q <= '0;
            bi_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            v1_q <= 1'b0;
            s1_q <= 1'b0;
            r2_q <= '0;
            i2_q <= '0;
            v2_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            ar_q <= ar_d;
            bi_q <= bi_d;
            ai_q <= ai_d;
            br_q <= br_d;
            v1_q <= v1_d;
            s1_q <= s1_d;
            r2_q <= r2_d;
            i2_q <= i2_d;
            v2_q <= v2_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_sof   = s2_q;
    assign out_r     = r2_q;
    assign out_i     = i2_q;

endmodule

// File: rtl/fft_16p_twiddle.sv
// fft_16p_twiddle: streaming W16^(k*n) multiplier between the two radix-4 SDF stages.
//   Holds the sample counter and twiddle ROM lookup; the multiply lives in fft_cmult.
//   Latency 2 cycles, no backpressure. Config macro FFT_TW_SAT_EN (see fft_cmult).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_sof     sample valid / start of frame (sof qualified by valid)
//   in_r, in_i           butterfly output sample (DW, signed)
//   out_valid, out_sof   in_valid / in_sof delayed by 2 cycles
//   out_r, out_i         twiddled sample (DW, signed)
module fft_16p_twiddle
    import fft_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    output logic          out_valid,
    output logic          out_sof,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i
);

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx;
    logic [3:0] e;
    cplx_t      tw;

    // k = idx[3:2] (butterfly group), n = idx[1:0] (position); sof realigns to idx 0.
    always_comb begin
        idx   = (in_valid && in_sof) ? 4'd0 : cnt_q;
        cnt_d = in_valid ? idx + 4'd1 : cnt_q;
        e     = {2'b00, idx[3:2]} * {2'b00, idx[1:0]};
        tw.re = TW_RE[e];
        tw.im = TW_IM[e];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    fft_cmult #(
        .DW (DW),
        .TW (TW)
    ) u_cmult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_r      (in_r),
        .in_i      (in_i),
        .tw_r      (TW'(tw.re)),
        .tw_i      (TW'(tw.im)),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_r     (out_r),
        .out_i     (out_i)
    );

endmodule

// File: tb/tb_fft_16p_twiddle.sv
// Self-checking bench for fft_16p_twiddle: scoreboard of expected outputs pushed on
// every accepted input, popped when out_valid appears two cycles later.
module tb_fft_16p_twiddle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sof;
    logic [15:0] in_r, in_i;
    logic        out_valid, out_sof;
    logic [15:0] out_r, out_i;

    always #5 clk = ~clk;

    fft_16p_twiddle #(.DW(16), .TW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_r     (out_r),
        .out_i     (out_i)
    );

    typedef struct {int r; int i; bit sof;} exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   mcnt  = 0;
    bit   hv0   = 1'b0;
    bit   hv1   = 1'b0;
    int   got_r [32];
    int   got_i [32];
    int   tw_re [10] = '{16384, 15137, 11585, 6270, 0, 0, -11585, 0, 0, -15137};
    int   tw_im [10] = '{0, -6270, -11585, -15137, -16384, 0, -11585, 0, 0, 6270};

    function automatic int reduce(input longint x);
        longint m;
`ifdef FFT_TW_SAT_EN
        m = x;
        if (m > 32767) m = 32767;
        if (m < -32768) m = -32768;
        return int'(m);
`else
        m = x & 64'hFFFF;
        return (m >= 32768) ? int'(m - 65536) : int'(m);
`endif
    endfunction

    function automatic exp_t model(input int a, input int b, input int idx, input bit s);
        exp_t   ex;
        int     e;
        longint pr, pim;
        e   = (idx / 4) * (idx % 4);
        pr  = longint'(a) * tw_re[e] - longint'(b) * tw_im[e];
        pim = longint'(a) * tw_im[e] + longint'(b) * tw_re[e];
        ex.r   = reduce((pr + 8192) >>> 14);
        ex.i   = reduce((pim + 8192) >>> 14);
        ex.sof = s;
        return ex;
    endfunction

    // Drive one cycle of input, predict its output, then step past the clock edge.
    // On return hv1 is the expected out_valid for this cycle.
    task automatic tick(input bit v, input bit s, input int r, input int i);
        int idx;
        in_valid = v;
        in_sof   = s;
        in_r     = r[15:0];
        in_i     = i[15:0];
        if (v) begin
            idx  = s ? 0 : mcnt;
            sb.push_back(model(r, i, idx, s));
            mcnt = (idx + 1) % 16;
        end
        hv1 = hv0;
        hv0 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_r !== 16'd0 || out_i !== 16'd0) begin
            fails++;
            $display("FAIL reset: got v=%b sof=%b r=%0d i=%0d, want all 0",
                     out_valid, out_sof, out_r, out_i);
        end
        rst_n = 1'b1;
        hv0 = 1'b0; hv1 = 1'b0; mcnt = 0;
    endtask

    task automatic test_passthrough();
        exp_t ex;
        for (int k = 0; k < 18; k++) begin
            tick(k < 16, k == 0, 1234, -567);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL pass_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL pass_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end
        end
    endtask

    task automatic test_twiddle_e1_e9();
        exp_t ex;
        int   n = 0;
        for (int k = 0; k < 18; k++) begin
            tick(k < 16, k == 0, 1000, 0);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL tw_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                got_r[n] = int'($signed(out_r)); got_i[n] = int'($signed(out_i)); n++;
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL tw_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end
        end
        tests++;
        if (got_r[5] !== 924 || got_i[5] !== -383) begin
            fails++; $display("FAIL tw_e1: got (%0d,%0d) want (924,-383)", got_r[5], got_i[5]);
        end
        tests++;
        if (got_r[15] !== -924 || got_i[15] !== 383) begin
            fails++;
            $display("FAIL tw_e9: got (%0d,%0d) want (-924,383)", got_r[15], got_i[15]);
        end
    endtask

    task automatic test_minus_j_overflow();
        exp_t ex;
        int   n = 0;
        int   r, i;
        int   want9_r;
`ifdef FFT_TW_SAT_EN
        want9_r = 32767;
`else
        want9_r = -19197;
`endif
        for (int k = 0; k < 18; k++) begin
            r = 500; i = -250;
            if (k == 9)  begin r = 32767; i = 32767; end
            if (k == 10) begin r = 100;   i = 200;   end
            tick(k < 16, k == 0, r, i);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL ovf_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                got_r[n] = int'($signed(out_r)); got_i[n] = int'($signed(out_i)); n++;
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL ovf_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end
        end
        tests++;
        if (got_r[10] !== 200 || got_i[10] !== -100) begin
            fails++;
            $display("FAIL minus_j: got (%0d,%0d) want (200,-100)", got_r[10], got_i[10]);
        end
        tests++;
        if (got_r[9] !== want9_r || got_i[9] !== 0) begin
            fails++;
            $display("FAIL overflow: got (%0d,%0d) want (%0d,0)", got_r[9], got_i[9], want9_r);
        end
    endtask

    task automatic test_gaps();
        exp_t ex;
        bit   v, s;
        logic [15:0] last_r, last_i;
        last_r = out_r; last_i = out_i;
        for (int k = 0; k < 50; k++) begin
            v = (k < 48) && (k == 0 || $urandom_range(0, 9) < 7);
            s = (k == 0) || (!v && $urandom_range(0, 3) == 0);
            tick(v, s, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL gap_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL gap_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end else begin
                tests++;
                if (out_r !== last_r || out_i !== last_i) begin
                    fails++;
                    $display("FAIL gap_hold: got (%0d,%0d) want (%0d,%0d)",
                             $signed(out_r), $signed(out_i), $signed(last_r), $signed(last_i));
                end
            end
            last_r = out_r; last_i = out_i;
        end
    endtask

    task automatic test_resync();
        exp_t ex;
        int   n = 0;
        bit   v, s;
        int   r, i;
        for (int k = 0; k < 19; k++) begin
            v = (k < 17) && (k != 12);
            s = (k == 0) || (k == 7) || (k == 12);
            r = int'($urandom_range(0, 4000)) - 2000;
            i = int'($urandom_range(0, 4000)) - 2000;
            if (k == 7) begin r = 777; i = -333; end
            tick(v, s, r, i);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL sync_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                got_r[n] = int'($signed(out_r)); got_i[n] = int'($signed(out_i)); n++;
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL sync_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end
        end
        tests++;
        if (got_r[7] !== 777 || got_i[7] !== -333) begin
            fails++;
            $display("FAIL sync_unity: got (%0d,%0d) want (777,-333)", got_r[7], got_i[7]);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t ex;
        for (int k = 0; k < 24; k++) begin
            if (k == 6) begin
                // Reset with a valid sample presented at cnt = 6: it must be dropped.
                rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_r = 16'd999; in_i = 16'd9;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                sb.delete(); hv0 = 1'b0; hv1 = 1'b0; mcnt = 0;
                tests++;
                if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_r !== 16'd0
                    || out_i !== 16'd0) begin
                    fails++;
                    $display("FAIL rst_mid: got v=%b sof=%b r=%0d i=%0d, want all 0",
                             out_valid, out_sof, out_r, out_i);
                end
                continue;
            end
            tick(k < 22, k == 0 || k == 7, 300 + k * 50, 40 - k * 30);
            tests++;
            if (out_valid !== hv1) begin
                fails++; $display("FAIL rst_valid: got %b want %b", out_valid, hv1);
            end else if (hv1) begin
                ex = sb.pop_front();
                tests++;
                if (int'($signed(out_r)) !== ex.r || int'($signed(out_i)) !== ex.i
                    || out_sof !== ex.sof) begin
                    fails++;
                    $display("FAIL rst_data: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                             $signed(out_r), $signed(out_i), out_sof, ex.r, ex.i, ex.sof);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_twiddle_e1_e9();
        test_minus_j_overflow();
        test_gaps();
        test_resync();
        test_reset_mid_frame();
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL drain: got %0d pending outputs want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
